// File: rtl/display_fmt_pkg.sv
// Shared types and constants for the $display argument formatter.
// Holds the format code enum, ASCII constants, field-width helpers and
// the FSM state encodings used by display_fmt_serializer.
package display_fmt_pkg;

    typedef enum logic [1:0] {
        FMT_DEC  = 2'd0,
        FMT_HEX  = 2'd1,
        FMT_BIN  = 2'd2,
        FMT_SDEC = 2'd3
    } fmt_e;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h61;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_CONVERT = 3'd1;
    localparam logic [ST_W-1:0] ST_EMIT    = 3'd2;
    localparam logic [ST_W-1:0] ST_NEWLINE = 3'd3;
    localparam logic [ST_W-1:0] ST_MAG     = 3'd4;

    // ceil(w*log10(2)); w*log10(2) is never an integer, so the fixed-point
    // approximation cannot cross a digit boundary for w <= 64.
    function automatic int unsigned dec_digits(input int unsigned w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    function automatic int unsigned hex_digits(input int unsigned w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
// The first bit is absorbed while loading, so o_done pulses WIDTH cycles
// after i_start; o_bcd then holds until the next start.
// Ports: clk, rst (async, active-high), i_start, i_value, o_done, o_bcd.
module bin2bcd_iter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [BCD_W-1:0] w_adj;

    // Add-3 correction for every digit >= 5 ahead of the shift.
    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dig
        assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                           : r_bcd[4*k +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_shift <= i_value << 1;
                r_bcd   <= BCD_W'(i_value[WIDTH-1]);
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_done  <= (WIDTH == 1);
            end else if (r_cnt != '0) begin
                r_bcd   <= {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt - CNT_W'(1);
                r_done  <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/display_fmt_serializer.sv
// Formats one $display argument (%d, %h, %b) into an ASCII byte stream,
// one byte per cycle on a valid/ready output, optionally followed by LF.
// Ports: clk, rst (async, active-high); arg_valid/arg_ready/arg_value/
// arg_fmt/arg_last token input; char_valid/char_ready/char_data byte
// output; busy while a token is in progress.
// Build option: FMT_SIGNED_EN enables arg_fmt=3 as signed decimal;
// otherwise arg_fmt=3 is plain unsigned decimal.
module display_fmt_serializer
    import display_fmt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_valid,
    output logic             arg_ready,
    input  logic [WIDTH-1:0] arg_value,
    input  logic [1:0]       arg_fmt,
    input  logic             arg_last,
    output logic             char_valid,
    input  logic             char_ready,
    output logic [7:0]       char_data,
    output logic             busy
);

    localparam int unsigned DEC_DIGITS = dec_digits(WIDTH);
    localparam int unsigned HEX_DIGITS = hex_digits(WIDTH);
    localparam int unsigned HEX_W      = 4 * HEX_DIGITS;
    localparam int unsigned BCD_W      = 4 * DEC_DIGITS;
    localparam int unsigned IDX_W      = $clog2(WIDTH + 2);

    logic [ST_W-1:0]  r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_char_valid, w_cv_nxt;
    logic [7:0]       r_char_data, w_cd_nxt;
    logic             r_arg_ready, r_busy;
    logic [WIDTH-1:0] r_value;
    fmt_e             r_fmt;
    logic             r_last;
    fmt_e             w_fmt_in;
    logic             w_load, w_start, w_done, w_neg;
    logic [WIDTH-1:0] w_conv_in;
    logic [BCD_W-1:0] w_bcd;

`ifdef FMT_SIGNED_EN
    logic             r_neg;
    logic [WIDTH-1:0] w_mag;
    assign w_fmt_in = fmt_e'(arg_fmt);
    assign w_neg    = r_neg;
    assign w_mag    = r_value[WIDTH-1] ? ((~r_value) + WIDTH'(1)) : r_value;
`else
    assign w_fmt_in = (arg_fmt == 2'd3) ? FMT_DEC : fmt_e'(arg_fmt);
    assign w_neg    = 1'b0;
`endif

    function automatic int unsigned field_len(input fmt_e f);
        case (f)
            FMT_HEX:  return HEX_DIGITS;
            FMT_BIN:  return WIDTH;
            FMT_SDEC: return DEC_DIGITS + 1;
            default:  return DEC_DIGITS;
        endcase
    endfunction

    // Character at field position pos (0 = leftmost) for the given token.
    function automatic logic [7:0] char_at(input fmt_e f, input logic [WIDTH-1:0] v,
                                           input logic [BCD_W-1:0] bcd, input logic neg,
                                           input int pos);
        logic [HEX_W-1:0] hv;
        logic [3:0]       nib;
        int               msd;
        int               kpos;
        logic [7:0]       c;
        hv  = HEX_W'(v);
        nib = 4'd0;
        msd = 0;
        kpos = 0;
        c   = ASC_SPACE;
        case (f)
            FMT_HEX: begin
                nib = 4'(hv >> (4 * (int'(HEX_DIGITS) - 1 - pos)));
                c   = (nib < 4'd10) ? (ASC_ZERO + 8'(nib)) : (ASC_A + 8'(nib) - 8'd10);
            end
            FMT_BIN: begin
                c = (1'(v >> (int'(WIDTH) - 1 - pos))) ? (ASC_ZERO + 8'd1) : ASC_ZERO;
            end
            default: begin
                // Digits above the most significant non-zero one are blanked;
                // digit 0 always prints, and '-' sits just left of the msd.
                for (int k = 0; k < int'(DEC_DIGITS); k++) begin
                    if (4'(bcd >> (4 * k)) != 4'd0) msd = k;
                end
                kpos = int'(field_len(f)) - 1 - pos;
                if (kpos > msd) begin
                    c = (neg && (kpos == msd + 1)) ? ASC_MINUS : ASC_SPACE;
                end else begin
                    c = ASC_ZERO + 8'(4'(bcd >> (4 * kpos)));
                end
            end
        endcase
        return c;
    endfunction

    bin2bcd_iter #(
        .WIDTH  (WIDTH),
        .DIGITS (DEC_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_value (w_conv_in),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cv_nxt    = r_char_valid;
        w_cd_nxt    = r_char_data;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_conv_in   = arg_value;
        case (r_state)
            ST_IDLE: begin
                if (arg_valid) begin
                    w_load = 1'b1;
                    case (w_fmt_in)
                        FMT_DEC: begin
                            w_start     = 1'b1;
                            w_state_nxt = ST_CONVERT;
                        end
`ifdef FMT_SIGNED_EN
                        FMT_SDEC: w_state_nxt = ST_MAG;
`endif
                        default: begin
                            w_state_nxt = ST_EMIT;
                            w_idx_nxt   = '0;
                            w_cv_nxt    = 1'b1;
                            w_cd_nxt    = char_at(w_fmt_in, arg_value, w_bcd, 1'b0, 0);
                        end
                    endcase
                end
            end
`ifdef FMT_SIGNED_EN
            ST_MAG: begin
                w_start     = 1'b1;
                w_conv_in   = w_mag;
                w_state_nxt = ST_CONVERT;
            end
`endif
            ST_CONVERT: begin
                if (w_done) begin
                    w_state_nxt = ST_EMIT;
                    w_idx_nxt   = '0;
                    w_cv_nxt    = 1'b1;
                    w_cd_nxt    = char_at(r_fmt, r_value, w_bcd, w_neg, 0);
                end
            end
            ST_EMIT: begin
                if (r_char_valid && char_ready) begin
                    if (r_idx == IDX_W'(field_len(r_fmt) - 1)) begin
                        if (r_last) begin
                            w_state_nxt = ST_NEWLINE;
                            w_cd_nxt    = ASC_LF;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_cv_nxt    = 1'b0;
                            w_cd_nxt    = 8'h00;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        w_cd_nxt  = char_at(r_fmt, r_value, w_bcd, w_neg, int'(r_idx) + 1);
                    end
                end
            end
            ST_NEWLINE: begin
                if (r_char_valid && char_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_cv_nxt    = 1'b0;
                    w_cd_nxt    = 8'h00;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cv_nxt    = 1'b0;
                w_cd_nxt    = 8'h00;
            end
        endcase
    end

    // State, registered outputs and latched token fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_char_valid <= 1'b0;
            r_char_data  <= 8'h00;
            r_arg_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_value      <= '0;
            r_fmt        <= FMT_DEC;
            r_last       <= 1'b0;
`ifdef FMT_SIGNED_EN
            r_neg        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_char_valid <= w_cv_nxt;
            r_char_data  <= w_cd_nxt;
            r_arg_ready  <= (w_state_nxt == ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_value <= arg_value;
                r_fmt   <= w_fmt_in;
                r_last  <= arg_last;
            end
`ifdef FMT_SIGNED_EN
            if (r_state == ST_MAG) begin
                r_neg <= r_value[WIDTH-1];
            end else if (w_load) begin
                r_neg <= 1'b0;
            end
`endif
        end
    end

    assign arg_ready  = r_arg_ready;
    assign busy       = r_busy;
    assign char_valid = r_char_valid;
    assign char_data  = r_char_data;

endmodule

// File: tb/tb_display_fmt_serializer.sv
// Directed self-checking bench for display_fmt_serializer (WIDTH=8).
module tb_display_fmt_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       arg_valid;
    logic       arg_ready;
    logic [7:0] arg_value;
    logic [1:0] arg_fmt;
    logic       arg_last;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_data;
    logic       busy;

    int         vec  = 0;
    int         miss = 0;
    logic [7:0] q[$];
    string      got_s = "";
    bit         ready_mode = 1'b0;
    int         rp = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    display_fmt_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .arg_valid  (arg_valid),
        .arg_ready  (arg_ready),
        .arg_value  (arg_value),
        .arg_fmt    (arg_fmt),
        .arg_last   (arg_last),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string got, input string exp);
        vec++;
        if (got != exp) begin
            miss++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    // Reference formatting from the printf rules, independent of the datapath.
    function automatic string model(input logic [7:0] v, input logic [1:0] f, input bit last);
        string s;
        int    n;
        int    fw;
        bit    neg;
        s   = "";
        neg = 1'b0;
        fw  = 3;
        n   = int'(v);
        if (f == 2'd1) begin
            s = $sformatf("%02x", v);
        end else if (f == 2'd2) begin
            s = $sformatf("%08b", v);
        end else begin
`ifdef FMT_SIGNED_EN
            if (f == 2'd3) begin
                fw = 4;
                if (v[7]) begin
                    neg = 1'b1;
                    n   = 256 - int'(v);
                end
            end
`endif
            do begin
                s = {$sformatf("%0d", n % 10), s};
                n = n / 10;
            end while (n > 0);
            if (neg) s = {"-", s};
            while (s.len() < fw) s = {" ", s};
        end
        if (last) s = {s, "\n"};
        return s;
    endfunction

    // One cycle: drive char_ready for the coming edge, then check outputs.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        rp++;
        char_ready = ready_mode ? ((rp % 3) == 0) : 1'b1;
        if (rst) begin
            chk("rst_arg_ready", 32'(arg_ready), 32'd1);
            chk("rst_char_valid", 32'(char_valid), 32'd0);
            chk("rst_char_data", 32'(char_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            q.delete();
            got_s      = "";
            prev_stall = 1'b0;
        end else begin
            chk("ready_vs_busy", 32'(arg_ready), 32'(!busy));
            if (prev_stall) begin
                chk("stall_valid", 32'(char_valid), 32'd1);
                chk("stall_data", 32'(char_data), 32'(prev_data));
            end
            if (char_valid && char_ready) begin
                if (q.size() == 0) begin
                    chk("extra_byte", 32'(char_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("char", 32'(char_data), 32'(e));
                end
                got_s = $sformatf("%s%c", got_s, char_data);
            end
            prev_stall = char_valid && !char_ready;
            prev_data  = char_data;
        end
    endtask

    task automatic send(input logic [7:0] v, input logic [1:0] f, input bit last, input int exp_lat);
        string s;
        int    n;
        int    lat;
        s = model(v, f, last);
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        arg_value = v;
        arg_fmt   = f;
        arg_last  = last;
        arg_valid = 1'b1;
        n = 0;
        while (!arg_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        tick();
        arg_valid = 1'b0;
        lat = 1;
        while (!char_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic wait_done(input string exp);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("done_timeout", 32'(n), 32'd0);
        chk("ready_after_last", 32'(arg_ready), 32'd1);
        chk_s("stream", got_s, exp);
        got_s = "";
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        arg_valid  = 1'b0;
        arg_value  = 8'h00;
        arg_fmt    = 2'd0;
        arg_last   = 1'b0;
        char_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        send(8'hAA, 2'd0, 1'b0, 9);  wait_done("170");
        send(8'h05, 2'd0, 1'b0, 9);  wait_done("  5");
        send(8'h00, 2'd0, 1'b0, 9);  wait_done("  0");
        send(8'hFF, 2'd0, 1'b0, 9);  wait_done("255");
        send(8'hAA, 2'd1, 1'b1, 1);  wait_done("aa\n");
        send(8'h0F, 2'd1, 1'b0, 1);  wait_done("0f");
        send(8'hFF, 2'd1, 1'b0, 1);  wait_done("ff");
        send(8'hFF, 2'd2, 1'b0, 1);  wait_done("11111111");
        send(8'h64, 2'd0, 1'b1, 9);  wait_done("100\n");

        ready_mode = 1'b1;
        send(8'h55, 2'd2, 1'b0, 1);  wait_done("01010101");
        send(8'h2A, 2'd0, 1'b1, 9);  wait_done(" 42\n");
        ready_mode = 1'b0;

        // Reset after two bytes of a %b token; the remainder must vanish.
        send(8'h55, 2'd2, 1'b0, 1);
        n = 0;
        while (got_s.len() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("two_bytes_before_rst", 32'(got_s.len()), 32'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        send(8'hFF, 2'd0, 1'b0, 9);  wait_done("255");

`ifdef FMT_SIGNED_EN
        send(8'hFB, 2'd3, 1'b0, 10); wait_done("  -5");
        send(8'h80, 2'd3, 1'b0, 10); wait_done("-128");
        send(8'h07, 2'd3, 1'b0, 10); wait_done("   7");
`else
        send(8'hFB, 2'd3, 1'b0, 9);  wait_done("251");
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/display_fmt_serializer.md
Name: display_fmt_serializer

Overview:
- Downstream stage for simulation `$display` events. Converts one captured argument value into the ASCII character stream that the format specifier produces.
- Supports %d, %h and %b with Verilog default field widths.
- Consumes (value, format, last) tokens on a valid/ready input and emits one byte per cycle on a valid/ready character output feeding the host print buffer.

Parameters:
- WIDTH, 8, bit width of the argument value (1..64).
- DEC_DIGITS, derived localparam = ceil(WIDTH*log10(2)), decimal field width (3 for WIDTH=8); not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- arg_valid  in  1  argument token valid
- arg_ready  out  1  block can accept a token
- arg_value  in  WIDTH  value to format
- arg_fmt  in  2  0=%d, 1=%h, 2=%b, 3=%d signed (see Optional Feature)
- arg_last  in  1  final argument of the display; append '\n' (8'h0A)
- char_valid  out  1  output byte valid
- char_ready  in  1  downstream accepts byte
- char_data  out  8  ASCII byte
- busy  out  1  token in progress (state != IDLE)

Behaviour:
- Reset values: arg_ready=1, char_valid=0, char_data=8'h00, busy=0. Internal BCD/shift registers are cleared.
- Reset mid-stream: the partial output is dropped and no further bytes of that token are emitted.
- FSM states and transitions:
  - IDLE: arg_ready=1. Accept on arg_valid&&arg_ready, then latch value, fmt and last. Go to CONVERT for %d, otherwise to EMIT.
  - CONVERT: iterative double-dabble, one bit per cycle, exactly WIDTH cycles, then go to EMIT. arg_ready=0.
  - EMIT: present digits MSB-first. Advance only on char_valid&&char_ready; char_data is held stable while char_ready=0. After the last digit, go to NEWLINE if last=1, else IDLE.
  - NEWLINE: emit 8'h0A with the same handshake, then go to IDLE.
- Latency: %h/%b have the first char_valid in the cycle after acceptance. %d has the first char_valid WIDTH+1 cycles after acceptance.
- Back-to-back: a new token is accepted in the cycle after the final byte handshake. There is no overlap: arg_ready=0 whenever busy.
- %h: exactly ceil(WIDTH/4) digits, zero-padded, lowercase a-f. A partial top nibble is zero-extended.
- %b: exactly WIDTH chars of '0'/'1'.
- %d (unsigned): exactly DEC_DIGITS chars. Leading zeros are replaced by spaces (8'h20), but the least significant digit is always a digit, so value 0 gives "  0".
- Width boundaries: all-ones value gives max-length output ("255", "ff", "11111111" for WIDTH=8). WIDTH=1 gives a single char for each format.

Optional Feature:
- Macro: FMT_SIGNED_EN.
- Defined: arg_fmt=3 treats the value as two's complement.
  - Field width is DEC_DIGITS+1.
  - A negative value emits '-' immediately before its first significant digit, with spaces to the left.
  - Positive values are space-padded to the same width.
  - The most negative value (8'h80) gives "-128".
  - Magnitude is computed before CONVERT, which adds 1 cycle of latency.
- Not defined: arg_fmt=3 behaves exactly as arg_fmt=0, and no negation logic is present.

Decomposition:
- Package display_fmt_pkg:
  - fmt code enum (FMT_DEC, FMT_HEX, FMT_BIN, FMT_SDEC).
  - ASCII constants (space, '0', 'a', '-', LF).
  - Constant functions for decimal digit count and hex digit count.
  - FSM state enum.
- Sub-module bin2bcd_iter: start/done, WIDTH-cycle double-dabble converter, DEC_DIGITS BCD digits out.

Test Plan:
- WIDTH=8, value 8'hAA, fmt 0, last=0 -> "170". The first char_valid arrives 9 cycles after acceptance.
- value 8'h05, fmt 0, then 8'h00, fmt 0 -> "  5" then "  0", with spaces as 8'h20.
- value 8'hAA, fmt 1, last=1 -> "aa" then 8'h0A; value 8'h0F, fmt 1 -> "0f".
- value 8'h55, fmt 2 with char_ready toggling 1,0,0,1,... -> "01010101". No byte is lost or duplicated, and char_data is stable while stalled.
- Assert rst after 2 bytes of a %b token, then send 8'hFF fmt 0 -> the output after reset is only "255", and outputs equal their reset values during rst.
- With FMT_SIGNED_EN: 8'hFB fmt 3 -> "  -5"; 8'h80 -> "-128"; 8'h07 -> "   7". Without the macro, 8'hFB fmt 3 -> "251".
